// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory stage: access-size codes,
// data-memory select encodings and the load/store unit state type.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] SEL_LBU = 3'b000;
  localparam logic [2:0] SEL_LB  = 3'b001;
  localparam logic [2:0] SEL_LHU = 3'b010;
  localparam logic [2:0] SEL_LH  = 3'b011;
  localparam logic [2:0] SEL_LW  = 3'b100;
  localparam logic [2:0] SEL_SB  = 3'b101;
  localparam logic [2:0] SEL_SH  = 3'b110;
  localparam logic [2:0] SEL_SW  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/mips_lane_align.sv
// Little-endian lane handling: right-justifies and extends sub-word loads,
// and merges sub-word store data into a previously read word.
module mips_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s  = word_i[{lane_i, 3'b000} +: 8];
    half_s  = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = unsigned_i ? {24'h000000, byte_s} : 32'(byte_s);
        merge_o = word_i;
        merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = unsigned_i ? {16'h0000, half_s} : 32'(half_s);
        merge_o = word_i;
        if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
        else           merge_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mips_load_store_unit.sv
// Memory-stage load/store controller: validates requests, issues full-word
// reads/writes to the data memory and returns extended load data.
module mips_load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int         MEM_WORDS = 256,
  parameter logic [2:0] WSEL      = SEL_LW,
  parameter logic [2:0] WSEL_ST   = SEL_SW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write,
  output logic        select2,
  output logic        select1,
  output logic        select0,
  input  logic [31:0] read_data
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  sel;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    if (size == 2'b11) bad = 1'b1;
    if (size == SZ_HALF && addr[0]) bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS)) bad = 1'b1;
    return bad;
  endfunction

  mips_lane_align u_align (
    .word_i     (read_data),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  assign {select2, select1, select0} = sel;

  // Only the state is reset; every output is decoded from it, so an
  // asynchronous reset drops the memory enables at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    write_q <= write_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
    word_q  <= word_d;
    rdata_q <= rdata_d;
    err_q   <= err_d;
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    write_d       = write_q;
    uns_d         = uns_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'h0;
    resp_err      = 1'b0;
    mem_address   = 32'h0;
    write_data    = 32'h0;
    sig_mem_read  = 1'b0;
    sig_mem_write = 1'b0;
    sel           = 3'b000;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          word_d  = req_wdata;
          rdata_d = 32'h0;
          err_d   = req_error(req_addr, req_size);
          if (err_d)                               state_d = ST_RESP;
          else if (req_write && req_size == SZ_WORD) state_d = ST_WRITE;
          else                                     state_d = ST_READ;
        end
      end
      ST_READ: begin
        sig_mem_read = 1'b1;
        sel          = WSEL;
        mem_address  = {2'b00, addr_q[31:2]};
        // Sub-word stores reuse this read to build the merged word.
        if (write_q) begin
          word_d  = merge_data;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        sig_mem_write = 1'b1;
        sel           = WSEL_ST;
        mem_address   = {2'b00, addr_q[31:2]};
        write_data    = word_q;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mips_load_store_unit.md
Name: mips_load_store_unit

Overview:
- Memory-stage controller sitting directly upstream of the MIPS data memory (256 x 32-bit, word-indexed).
- Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake.
- Drives the data memory control port: word index, write data, sig_mem_read, sig_mem_write, select2..0.
- Performs lane extraction, sign/zero extension and read-modify-write merging itself, so the memory only ever sees full-word accesses.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; legal byte addresses are 0 to 4*MEM_WORDS-1.
- WSEL, 3'b100, select2..0 code for a full-word read.
- WSEL_ST, 3'b111, select2..0 code for a full-word write.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low-order bits.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal-size request.
- mem_address  out  32  word index = req_addr[31:2].
- write_data  out  32  word written to memory.
- sig_mem_read  out  1  memory read enable.
- sig_mem_write  out  1  memory write enable.
- select2, select1, select0  out  1 each  memory access-type select.
- read_data  in  32  memory read data, combinational from mem_address.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_address=0; write_data=0; sig_mem_read=0; sig_mem_write=0; select2..0=000.
- A reset asserted mid-operation aborts immediately; memory enables drop in the same instant, and no partial write completes after reset.
- States: IDLE, READ, WRITE, RESP.
- Acceptance: a request is accepted on a rising edge where req_valid and req_ready are both 1. Address, size, write flag, unsigned flag and wdata are registered at that edge.
- Error check happens at acceptance; any of the following go straight to RESP with resp_err=1 and no memory access:
  - req_size=11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr[31:2] >= MEM_WORDS.
- Transitions out of IDLE on acceptance:
  - Any load -> READ.
  - Word store -> WRITE.
  - Byte or halfword store -> READ.
- READ (exactly 1 cycle):
  - sig_mem_read=1, select=WSEL, mem_address=word index.
  - read_data is captured at the end of the cycle.
  - Load -> RESP.
  - Sub-word store -> WRITE, with the merged word computed from the captured data.
- WRITE (exactly 1 cycle):
  - sig_mem_write=1, select=WSEL_ST.
  - write_data is the full word for a word store, otherwise the merged word.
  - Then -> RESP.
- Lane rules (little-endian lanes by addr[1:0]):
  - Byte uses lane addr[1:0]; halfword uses lane addr[1].
  - Store merge replaces only the addressed byte or halfword of the captured word.
  - Load data is right-justified, then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1).
- RESP: resp_valid=1 and resp_rdata/resp_err are held stable until resp_ready=1. On that edge -> IDLE.
- Enables and select are 0/000 in every state other than READ and WRITE.
- Latency from acceptance to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: one request in flight; the next can be accepted on the cycle after the RESP handshake.
- resp_ready asserted outside RESP is ignored.

Decomposition:
- Shared package mips_mem_pkg holds:
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
  - The eight select2..0 encodings: 000 lbu, 001 lb, 010 lhu, 011 lh, 100 lw, 101 sb, 110 sh, 111 sw.
  - The state enum.
- One combinational sub-module, mips_lane_align, does load extraction/extension and store merging from (word, addr[1:0], size, unsigned, wdata).
- The FSM and registers stay in mips_load_store_unit.

Test Plan:
- Word store addr 0x10, wdata 0xDEADBEEF, then word load addr 0x10 -> one WRITE cycle with mem_address=4 and select 111; load returns 0xDEADBEEF, resp_err=0, 2 cycles after acceptance.
- Memory word 4 = 0x1234_80FF; signed byte load addr 0x11 -> 0xFFFFFF80; unsigned byte load addr 0x11 -> 0x00000080; signed halfword load addr 0x12 -> 0x00001234.
- Memory word 4 = 0xAABBCCDD; byte store addr 0x12 with wdata 0x00000055 -> READ, then WRITE with write_data 0xAA55CCDD, resp 3 cycles after acceptance.
- Halfword load addr 0x13, word store addr 0x0E, and word load addr 0x400 -> each gives resp_err=1 after 1 cycle, with sig_mem_read and sig_mem_write never asserted.
- Load in flight with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable, req_ready=0; one cycle after resp_ready=1 the unit accepts a new request.
- Assert rst during the WRITE cycle of a sub-word store -> all outputs return to reset values immediately and req_ready=1 after release.
